// File: rtl/debug_pkg.sv
// Shared command bytes, FSM state encoding and frame geometry for the pipeline
// debug controller.
package debug_pkg;

    localparam logic [7:0] CMD_RESET = 8'h43;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] CMD_PAUSE = 8'h50;

    localparam int CNT_W       = 16;
    localparam int FRAME_BYTES = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_STEP,
        ST_SNAP,
        ST_SEND
    } state_t;

endpackage

// File: rtl/debug_frame_tx.sv
// Snapshot registers plus byte serializer: captures the pipeline observation
// words on i_load and streams them MSB-first over a valid/ready byte port.
module debug_frame_tx
    import debug_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic [DATA_W-1:0] i_pc_addr,
    input  logic [DATA_W-1:0] i_pc_instr,
    input  logic [DATA_W-1:0] i_reg_w,
    input  logic [DATA_W-1:0] i_reg_rt,
    input  logic [DATA_W-1:0] i_reg_rs,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_done
);

    localparam int FRAME_W = CNT_W + 5 * DATA_W;
    localparam int NBYTES  = FRAME_W / 8;
    localparam int IDX_W   = $clog2(NBYTES);

    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_pc_addr;
    logic [DATA_W-1:0]  r_pc_instr;
    logic [DATA_W-1:0]  r_reg_w;
    logic [DATA_W-1:0]  r_reg_rt;
    logic [DATA_W-1:0]  r_reg_rs;
    logic [IDX_W-1:0]   r_idx;
    logic               r_pending;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;

    logic [FRAME_W-1:0] w_frame;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_accept;
    logic               w_last;

    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f,
                                              input logic [IDX_W-1:0]   idx);
        return f[FRAME_W - 1 - 8 * int'(idx) -: 8];
    endfunction

    assign w_frame   = {r_cnt, r_pc_addr, r_pc_instr, r_reg_w, r_reg_rt, r_reg_rs};
    assign w_idx_nxt = r_idx + IDX_W'(1);
    assign w_accept  = r_tx_valid & i_tx_ready;
    assign w_last    = (r_idx == IDX_W'(NBYTES - 1));

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_done     = w_accept & w_last;

    // r_pending delays tx_valid by one cycle so the first byte is read from
    // the freshly loaded snapshot rather than the live inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_pc_addr  <= '0;
            r_pc_instr <= '0;
            r_reg_w    <= '0;
            r_reg_rt   <= '0;
            r_reg_rs   <= '0;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (i_load) begin
            r_cnt      <= i_cnt;
            r_pc_addr  <= i_pc_addr;
            r_pc_instr <= i_pc_instr;
            r_reg_w    <= i_reg_w;
            r_reg_rt   <= i_reg_rt;
            r_reg_rs   <= i_reg_rs;
            r_idx      <= '0;
            r_pending  <= 1'b1;
        end else if (r_pending) begin
            r_pending  <= 1'b0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= frame_byte(w_frame, r_idx);
        end else if (w_accept) begin
            if (w_last) begin
                r_tx_valid <= 1'b0;
            end else begin
                r_idx     <= w_idx_nxt;
                r_tx_data <= frame_byte(w_frame, w_idx_nxt);
            end
        end
    end

endmodule

// File: rtl/debug_unit.sv
// Host-side debug controller: decodes UART command bytes, runs/steps/resets the
// pipeline and ships a 22-byte observation frame back to the host.
module debug_unit
    import debug_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] HALT_INSTR = {DATA_W{1'b1}},
    parameter logic [CNT_W-1:0]  MAX_CYCLES = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              pc_enable_out,
    output logic              pc_reset_out,
    input  logic [DATA_W-1:0] pc_addr_in,
    input  logic [DATA_W-1:0] pc_instr_in,
    input  logic [DATA_W-1:0] reg_w_data_in,
    input  logic [DATA_W-1:0] reg_rt_data_in,
    input  logic [DATA_W-1:0] reg_rs_data_in,
    output logic              busy_out
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic w_pause;
    logic w_stop;
    logic w_load;
    logic w_done;

    // Stop is evaluated in the same cycle it is seen, so a halt word is never
    // clocked past its stage and a pause takes effect without a stray step.
    assign w_pause = rx_valid && (rx_data == CMD_PAUSE);
    assign w_stop  = (pc_instr_in == HALT_INSTR) || w_pause || (r_cycle_cnt == MAX_CYCLES);

    assign pc_enable_out = (r_state == ST_STEP) || ((r_state == ST_RUN) && !w_stop);
    assign pc_reset_out  = (r_state == ST_RESET);
    assign busy_out      = (r_state != ST_IDLE);
    assign w_load        = (r_state == ST_SNAP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cycle_cnt <= '0;
        end else begin
            if (r_state == ST_RESET) begin
                r_cycle_cnt <= '0;
            end else if (pc_enable_out && (r_cycle_cnt != MAX_CYCLES)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_RESET: r_state <= ST_RESET;
                            CMD_RUN:   r_state <= ST_RUN;
                            CMD_STEP:  r_state <= ST_STEP;
                            CMD_DUMP:  r_state <= ST_SNAP;
                            default:   r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_RESET: r_state <= ST_IDLE;
                ST_RUN:   if (w_stop) r_state <= ST_SNAP;
                ST_STEP:  r_state <= ST_SNAP;
                ST_SNAP:  r_state <= ST_SEND;
                ST_SEND:  if (w_done) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    debug_frame_tx #(
        .DATA_W (DATA_W)
    ) u_frame_tx (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_cnt      (r_cycle_cnt),
        .i_pc_addr  (pc_addr_in),
        .i_pc_instr (pc_instr_in),
        .i_reg_w    (reg_w_data_in),
        .i_reg_rt   (reg_rt_data_in),
        .i_reg_rs   (reg_rs_data_in),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_done     (w_done)
    );

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: a toy pipeline feeds the observation ports,
// a command-level model predicts enable counts and frame bytes.
module tb_debug_unit;
    import debug_pkg::*;

    localparam logic [15:0] MAXC = 16'd20;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        pc_enable_out;
    logic        pc_reset_out;
    logic        busy_out;
    logic [31:0] pc_addr_in, pc_instr_in, reg_w_data_in, reg_rt_data_in, reg_rs_data_in;

    logic [31:0] prog [0:255];
    logic [31:0] pl_pc = 32'd0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    int mon_pos = 0;
    int en_cnt = 0;
    int rst_cnt = 0;
    int busy_cnt = 0;
    bit rand_ready = 1'b0;
    int stall_at = -1;

    logic [31:0] m_pc = 32'd0;
    logic [15:0] m_cnt = 16'd0;

    always #5 clk = ~clk;

    debug_unit #(
        .DATA_W     (32),
        .HALT_INSTR (HALT),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .pc_enable_out  (pc_enable_out),
        .pc_reset_out   (pc_reset_out),
        .pc_addr_in     (pc_addr_in),
        .pc_instr_in    (pc_instr_in),
        .reg_w_data_in  (reg_w_data_in),
        .reg_rt_data_in (reg_rt_data_in),
        .reg_rs_data_in (reg_rs_data_in),
        .busy_out       (busy_out)
    );

    function automatic logic [31:0] f_w(input logic [31:0] pc);
        return pc ^ 32'hA5A5_5A5A;
    endfunction
    function automatic logic [31:0] f_rt(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} + 32'd7;
    endfunction
    function automatic logic [31:0] f_rs(input logic [31:0] pc);
        return ~pc;
    endfunction

    // Toy pipeline: PC advances by 4 per enabled cycle, observation words follow the PC.
    always @(posedge clk) begin
        if (pc_reset_out) pl_pc <= 32'd0;
        else if (pc_enable_out) pl_pc <= pl_pc + 32'd4;
    end
    assign pc_addr_in     = pl_pc;
    assign pc_instr_in    = prog[pl_pc[9:2]];
    assign reg_w_data_in  = f_w(pl_pc);
    assign reg_rt_data_in = f_rt(pl_pc);
    assign reg_rs_data_in = f_rs(pl_pc);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: counts control pulses and pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pc_enable_out) en_cnt++;
            if (pc_reset_out) rst_cnt++;
            if (busy_out) busy_cnt++;
            if (pc_enable_out && pc_reset_out) check("enable_reset_exclusive", 64'd1, 64'd0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx_byte actual=%0h required=none", tx_data);
                end else begin
                    check($sformatf("frame_byte%0d", mon_pos), tx_data, exp_q.pop_front());
                end
                mon_pos = (mon_pos + 1) % FRAME_BYTES;
            end
        end
    end

    // Ready driver: optional random backpressure and a one-off 5-cycle stall.
    always begin
        logic [7:0] held;
        @(posedge clk);
        #1;
        if (stall_at >= 0 && tx_valid && mon_pos == stall_at) begin
            held = tx_data;
            tx_ready = 1'b0;
            repeat (5) begin
                @(negedge clk);
                check("stall_valid_held", tx_valid, 1'b1);
                check("stall_data_stable", tx_data, held);
                @(posedge clk);
                #1;
            end
            stall_at = -1;
            tx_ready = 1'b1;
        end else begin
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic int halt_dist(input logic [31:0] pc);
        logic [31:0] a;
        for (int i = 0; i <= int'(MAXC); i++) begin
            a = pc + 32'(4 * i);
            if (prog[a[9:2]] == HALT) return i;
        end
        return 1000;
    endfunction

    task automatic push_frame();
        logic [175:0] f;
        f = {m_cnt, m_pc, prog[m_pc[9:2]], f_w(m_pc), f_rt(m_pc), f_rs(m_pc)};
        for (int k = 0; k < FRAME_BYTES; k++) exp_q.push_back(f[175 - 8 * k -: 8]);
    endtask

    task automatic do_cmd(input logic [7:0] cmd, input int pause_k, input bit inject_s,
                          input int abort_at);
        int n;
        int t;
        bit injected;
        n = 0;
        case (cmd)
            CMD_RESET: begin
                m_pc = 32'd0;
                m_cnt = 16'd0;
            end
            CMD_RUN: begin
                n = halt_dist(m_pc);
                if (int'(MAXC) - int'(m_cnt) < n) n = int'(MAXC) - int'(m_cnt);
                if (pause_k >= 0 && pause_k < n) n = pause_k;
                m_pc = m_pc + 32'(4 * n);
                m_cnt = m_cnt + 16'(n);
                push_frame();
            end
            CMD_STEP: begin
                n = 1;
                m_pc = m_pc + 32'd4;
                if (m_cnt < MAXC) m_cnt = m_cnt + 16'd1;
                push_frame();
            end
            CMD_DUMP: push_frame();
            default: ;
        endcase

        @(posedge clk);
        #1;
        en_cnt = 0;
        rst_cnt = 0;
        busy_cnt = 0;
        rx_data = cmd;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (cmd == CMD_RUN && pause_k >= 0) begin
            repeat (pause_k) @(posedge clk);
            #1;
            rx_data = CMD_PAUSE;
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end

        if (abort_at >= 0) begin
            t = 0;
            while (mon_pos != abort_at && t < 400) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 400) check("abort_wait_timeout", 64'(t), 64'd0);
            @(posedge clk);
            #3;
            reset_n = 1'b0;
            #1;
            check("abort_tx_valid", tx_valid, 1'b0);
            check("abort_busy", busy_out, 1'b0);
            check("abort_tx_data", tx_data, 8'h00);
            exp_q.delete();
            mon_pos = 0;
            m_cnt = 16'd0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            return;
        end

        t = 0;
        injected = 1'b0;
        do begin
            @(negedge clk);
            t++;
            if (inject_s && !injected && tx_valid) begin
                injected = 1'b1;
                @(posedge clk);
                #1;
                rx_data = CMD_STEP;
                rx_valid = 1'b1;
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
            end
        end while (busy_out && t < 400);
        if (t >= 400) check("idle_timeout", 64'(t), 64'd0);
        repeat (2) @(negedge clk);

        check($sformatf("enable_cycles_cmd%0h", cmd), 64'(en_cnt), 64'(n));
        check($sformatf("reset_pulses_cmd%0h", cmd), 64'(rst_cnt), (cmd == CMD_RESET) ? 64'd1 : 64'd0);
        check($sformatf("frame_drained_cmd%0h", cmd), 64'(exp_q.size()), 64'd0);
        check("tx_valid_idle", tx_valid, 1'b0);
        if (cmd == CMD_RESET) check("reset_busy_cycles", 64'(busy_cnt), 64'd1);
        if (cmd != CMD_RESET && cmd != CMD_RUN && cmd != CMD_STEP && cmd != CMD_DUMP)
            check("ignored_busy_cycles", 64'(busy_cnt), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int pk;
        for (int i = 0; i < 256; i++) begin
            prog[i] = $urandom;
            if (prog[i] == HALT) prog[i] = 32'd0;
        end
        prog[9]  = HALT;
        prog[60] = HALT;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_pc_enable", pc_enable_out, 1'b0);
        check("rst_pc_reset", pc_reset_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        reset_n = 1'b1;

        do_cmd(CMD_RESET, -1, 1'b0, -1);

        stall_at = 3;
        do_cmd(CMD_STEP, -1, 1'b0, -1);
        check("stall_consumed", 64'(stall_at), 64'(-1));

        do_cmd(CMD_RESET, -1, 1'b0, -1);
        do_cmd(CMD_RUN, -1, 1'b0, -1);

        do_cmd(CMD_RESET, -1, 1'b0, -1);
        do_cmd(CMD_RUN, 5, 1'b1, -1);

        prog[9] = 32'h0000_1234;
        do_cmd(CMD_RESET, -1, 1'b0, -1);
        do_cmd(CMD_RUN, -1, 1'b0, -1);
        do_cmd(CMD_RUN, -1, 1'b0, -1);

        do_cmd(CMD_DUMP, -1, 1'b0, 8);
        do_cmd(CMD_DUMP, -1, 1'b0, -1);

        prog[30] = HALT;
        rand_ready = 1'b1;
        repeat (40) begin
            r = $urandom_range(0, 9);
            pk = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 8));
            case (r)
                0:       do_cmd(CMD_RESET, -1, 1'b0, -1);
                1, 2, 3: do_cmd(CMD_RUN, pk, 1'b0, -1);
                4, 5, 6: do_cmd(CMD_STEP, -1, 1'b0, -1);
                7:       do_cmd(CMD_DUMP, -1, 1'b0, -1);
                8:       do_cmd(($urandom_range(0, 1) == 0) ? CMD_PAUSE : 8'h7A, -1, 1'b0, -1);
                default: do_cmd(CMD_RUN, -1, 1'b0, -1);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
